// File: rtl/fetch_inst_buffer_if.sv
// Fetch/decode side bundle of the instruction buffer.
// Master is the fetch/decode environment; slave is the buffer itself.
interface fetch_inst_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              valid_1_i;
  logic [ADDR_W-1:0] pc_1_i;
  logic [DATA_W-1:0] inst_1_i;
  logic              valid_2_i;
  logic [ADDR_W-1:0] pc_2_i;
  logic [DATA_W-1:0] inst_2_i;
  logic [1:0]        pop_num_i;

  logic              valid_1_o;
  logic [ADDR_W-1:0] pc_1_o;
  logic [DATA_W-1:0] inst_1_o;
  logic              valid_2_o;
  logic [ADDR_W-1:0] pc_2_o;
  logic [DATA_W-1:0] inst_2_o;
  logic              stall_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output flush_i, valid_1_i, pc_1_i, inst_1_i, valid_2_i, pc_2_i, inst_2_i, pop_num_i,
    input  valid_1_o, pc_1_o, inst_1_o, valid_2_o, pc_2_o, inst_2_o, stall_o, count_o
  );

  modport slave (
    input  flush_i, valid_1_i, pc_1_i, inst_1_i, valid_2_i, pc_2_i, inst_2_i, pop_num_i,
    output valid_1_o, pc_1_o, inst_1_o, valid_2_o, pc_2_o, inst_2_o, stall_o, count_o
  );
endinterface

// File: rtl/fetch_inst_buffer.sv
// Two-in / two-out instruction queue between fetch and dual-issue decode.
// Circular storage with first-word fall-through; stalls fetch when fewer
// than two free entries remain; branch redirect empties it.
module fetch_inst_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  fetch_inst_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              stall;
  logic              push_en;
  logic              we_0;
  logic              we_1;
  logic [ADDR_W-1:0] pc_d0;
  logic [DATA_W-1:0] inst_d0;
  logic [PTR_W-1:0]  wr_ptr_1;
  logic [PTR_W-1:0]  rd_ptr_1;
  logic [1:0]        push_n;
  logic [1:0]        pop_n;

  // Pop request 3 means 2, and never take more than what is stored.
  function automatic logic [1:0] clamp_pop(input logic [1:0] req, input logic [CNT_W-1:0] cnt);
    logic [1:0] lim;
    lim = (req == 2'd3) ? 2'd2 : req;
    if (CNT_W'(lim) > cnt) lim = cnt[1:0];
    return lim;
  endfunction

  // Push/pop decode; stall looks only at registered occupancy.
  always_comb begin
    stall    = (count > CNT_W'(DEPTH - 2));
    push_en  = !stall && !bus.flush_i;
    we_0     = push_en && (bus.valid_1_i || bus.valid_2_i);
    we_1     = push_en && bus.valid_1_i && bus.valid_2_i;
    // A lone slot-2 result still lands at the write pointer.
    pc_d0    = bus.valid_1_i ? bus.pc_1_i   : bus.pc_2_i;
    inst_d0  = bus.valid_1_i ? bus.inst_1_i : bus.inst_2_i;
    push_n   = 2'(we_0) + 2'(we_1);
    pop_n    = clamp_pop(bus.pop_num_i, count);
    wr_ptr_1 = wr_ptr + PTR_W'(1);
    rd_ptr_1 = rd_ptr + PTR_W'(1);
  end

  // Entry storage; contents are not reset, occupancy alone marks validity.
  always_ff @(posedge clk) begin
    if (we_0) begin
      pc_mem[wr_ptr]   <= pc_d0;
      inst_mem[wr_ptr] <= inst_d0;
    end
    if (we_1) begin
      pc_mem[wr_ptr_1]   <= bus.pc_2_i;
      inst_mem[wr_ptr_1] <= bus.inst_2_i;
    end
  end

  // Pointers and occupancy; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  // Fall-through view of the two oldest entries, zeroed when not valid.
  always_comb begin
    bus.valid_1_o = (count != '0);
    bus.valid_2_o = (count >= CNT_W'(2));
    bus.pc_1_o    = bus.valid_1_o ? pc_mem[rd_ptr]     : '0;
    bus.inst_1_o  = bus.valid_1_o ? inst_mem[rd_ptr]   : '0;
    bus.pc_2_o    = bus.valid_2_o ? pc_mem[rd_ptr_1]   : '0;
    bus.inst_2_o  = bus.valid_2_o ? inst_mem[rd_ptr_1] : '0;
    bus.stall_o   = stall;
    bus.count_o   = count;
  end
endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Self-checking bench for fetch_inst_buffer: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_fetch_inst_buffer;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  ent_t q[$];

  fetch_inst_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_inst_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic compare_all(input string tag);
    int sz;
    sz = q.size();
    check({tag, ":count"},  64'(bus.count_o),   64'(sz));
    check({tag, ":stall"},  64'(bus.stall_o),   64'((DEPTH - sz) < 2));
    check({tag, ":v1"},     64'(bus.valid_1_o), 64'(sz >= 1));
    check({tag, ":v2"},     64'(bus.valid_2_o), 64'(sz >= 2));
    check({tag, ":pc1"},    64'(bus.pc_1_o),    (sz >= 1) ? 64'(q[0].pc)   : 64'd0);
    check({tag, ":inst1"},  64'(bus.inst_1_o),  (sz >= 1) ? 64'(q[0].inst) : 64'd0);
    check({tag, ":pc2"},    64'(bus.pc_2_o),    (sz >= 2) ? 64'(q[1].pc)   : 64'd0);
    check({tag, ":inst2"},  64'(bus.inst_2_o),  (sz >= 2) ? 64'(q[1].inst) : 64'd0);
  endtask

  task automatic drive(input bit v1, input logic [ADDR_W-1:0] p1,
                       input bit v2, input logic [ADDR_W-1:0] p2,
                       input int pop, input bit fl);
    bus.valid_1_i = v1;
    bus.pc_1_i    = p1;
    bus.inst_1_i  = p1 ^ 32'h5A5A_A5A5;
    bus.valid_2_i = v2;
    bus.pc_2_i    = p2;
    bus.inst_2_i  = p2 ^ 32'hC3C3_3C3C;
    bus.pop_num_i = 2'(pop);
    bus.flush_i   = fl;
  endtask

  // One clock: update the model from pre-edge state and inputs, then compare.
  task automatic step(input string tag);
    int sz;
    int pn;
    @(posedge clk);
    sz = q.size();
    if (bus.flush_i) begin
      q.delete();
    end else begin
      pn = (bus.pop_num_i == 2'd3) ? 2 : int'(bus.pop_num_i);
      if (pn > sz) pn = sz;
      repeat (pn) void'(q.pop_front());
      if (DEPTH - sz >= 2) begin
        if (bus.valid_1_i) q.push_back('{pc: bus.pc_1_i, inst: bus.inst_1_i});
        if (bus.valid_2_i) q.push_back('{pc: bus.pc_2_i, inst: bus.inst_2_i});
      end
    end
    #1;
    compare_all(tag);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #12;
    compare_all("reset");
    rst = 1'b0;

    // Reset mid-stream, asynchronously between edges.
    drive(1, 32'h0, 1, 32'h4, 0, 0);
    step("rs_push2");
    drive(1, 32'h8, 0, 0, 0, 0);
    step("rs_push1");
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    q.delete();
    check("rs_v1", 64'(bus.valid_1_o), 64'd0);
    check("rs_v2", 64'(bus.valid_2_o), 64'd0);
    check("rs_count", 64'(bus.count_o), 64'd0);
    check("rs_stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;

    // Fill and stall.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(8 * i), 1, 32'(8 * i + 4), 0, 0);
      step("fill");
    end
    check("fill_stall", 64'(bus.stall_o), 64'd1);
    drive(1, 32'h20, 1, 32'h24, 0, 0);
    step("fill_ignored");
    check("fill_count", 64'(bus.count_o), 64'd8);
    check("fill_pc1", 64'(bus.pc_1_o), 64'h0);
    check("fill_pc2", 64'(bus.pc_2_o), 64'h4);
    drive(0, 0, 0, 0, 1, 0);
    step("pop_to7");
    check("c7_count", 64'(bus.count_o), 64'd7);
    check("c7_stall", 64'(bus.stall_o), 64'd1);

    // Drain with clamping.
    drive(0, 0, 0, 0, 0, 1);
    step("drain_flush");
    drive(1, 32'h100, 1, 32'h104, 0, 0);
    step("drain_p2");
    drive(1, 32'h108, 0, 0, 0, 0);
    step("drain_p1");
    drive(0, 0, 0, 0, 2, 0);
    step("drain_pop2");
    check("drain_head", 64'(bus.pc_1_o), 64'h108);
    check("drain_v2", 64'(bus.valid_2_o), 64'd0);
    drive(0, 0, 0, 0, 2, 0);
    step("drain_clamp");
    check("drain_empty", 64'(bus.count_o), 64'd0);
    drive(0, 0, 0, 0, 3, 0);
    step("drain_under");
    check("drain_noneg", 64'(bus.count_o), 64'd0);

    // Lone slot-2 push into an empty queue.
    drive(0, 0, 1, 32'h24, 0, 0);
    bus.inst_2_i = 32'hDEADBEEF;
    step("slot2");
    check("slot2_v1", 64'(bus.valid_1_o), 64'd1);
    check("slot2_pc", 64'(bus.pc_1_o), 64'h24);
    check("slot2_inst", 64'(bus.inst_1_o), 64'hDEADBEEF);
    check("slot2_v2", 64'(bus.valid_2_o), 64'd0);

    // Simultaneous push and pop across pointer wrap.
    drive(0, 0, 0, 0, 0, 1);
    step("wrap_flush");
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h10 + 32'(8 * i), 1, 32'h14 + 32'(8 * i), 0, 0);
      step("wrap_fill");
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 2, 0);
      step("wrap_drain");
    end
    drive(1, 32'h30, 1, 32'h34, 0, 0);
    step("wrap_pre");
    check("wrap_rd6", 64'(dut.rd_ptr), 64'd6);
    drive(1, 32'h40, 1, 32'h44, 2, 0);
    step("wrap_pushpop");
    check("wrap_count", 64'(bus.count_o), 64'd2);
    check("wrap_pc1", 64'(bus.pc_1_o), 64'h40);
    check("wrap_pc2", 64'(bus.pc_2_o), 64'h44);
    check("wrap_rd0", 64'(dut.rd_ptr), 64'd0);

    // Flush beats same-cycle push and pop.
    drive(0, 0, 0, 0, 0, 1);
    step("fp_flush0");
    drive(1, 32'h50, 1, 32'h54, 0, 0);
    step("fp_a");
    drive(1, 32'h58, 1, 32'h5C, 0, 0);
    step("fp_b");
    drive(1, 32'h60, 0, 0, 0, 0);
    step("fp_c");
    check("fp_count5", 64'(bus.count_o), 64'd5);
    drive(1, 32'h70, 1, 32'h74, 1, 1);
    step("fp_flush");
    check("fp_count0", 64'(bus.count_o), 64'd0);
    check("fp_v1", 64'(bus.valid_1_o), 64'd0);
    check("fp_v2", 64'(bus.valid_2_o), 64'd0);
    drive(1, 32'h80, 1, 32'h84, 0, 0);
    step("fp_repush");
    check("fp_head", 64'(bus.pc_1_o), 64'h80);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, $urandom,
            int'($urandom % 4), ($urandom % 40) == 0);
      step("rand");
    end

    drive(0, 0, 0, 0, 0, 0);
    step("idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
